shift_request_conditioner: RTL and testbench

Input-side front end for the gearbox FSM. It takes raw, bouncing, asynchronous push-button levels (up, down, brake) and turns them into clean commands. Shift commands are issued as level requests and held until the FSM's slow clock-enable tick consumes them, so no press is lost across the fast-to-slow rate boundary. It sits between the board buttons and the gearbox FSM inside the top-level wrapper, on the fast board clock.

---
 rtl/shift_request_conditioner_pkg.sv | 13 +
 rtl/shift_request_conditioner_debounce_channel.sv | 45 ++++
 rtl/shift_request_conditioner.sv | 102 ++++++++++
 tb/tb_shift_request_conditioner.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/shift_request_conditioner_pkg.sv
// Shared types and constants for the shift request conditioner.
package shift_request_conditioner_pkg;

    // 10 ms of stable level at a 25 MHz board clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PEND_UP   = 2'd1,
        PEND_DOWN = 2'd2
    } gear_cmd_state_t;

endpackage

// File: rtl/shift_request_conditioner_debounce_channel.sv
// One button channel: two-flop synchronizer followed by a stable-level debouncer.
module debounce_channel
    import shift_request_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_level;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
        end else begin
            sync_meta  <= raw;
            sync_level <= sync_meta;
        end
    end

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= 1'b0;
            count  <= '0;
        end else if (sync_level == stable) begin
            count <= '0;
        end else if (count == CNT_MAX) begin
            stable <= sync_level;
            count  <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/shift_request_conditioner.sv
// Turns bouncing push-buttons into held shift requests that survive until the
// gearbox FSM consumes them on its slow tick.
module shift_request_conditioner
    import shift_request_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic up_btn,
    input  logic down_btn,
    input  logic brake_btn,
    output logic shift_up,
    output logic shift_down,
    output logic brake,
    output logic dropped
);

    logic stable_up;
    logic stable_down;
    logic stable_brake;
    logic prev_up;
    logic prev_down;
    logic up_event;
    logic down_event;
    logic drop_next;

    gear_cmd_state_t state;
    gear_cmd_state_t next_state;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .reset(reset), .raw(up_btn), .stable(stable_up)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .reset(reset), .raw(down_btn), .stable(stable_down)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_brake (
        .clk(clk), .reset(reset), .raw(brake_btn), .stable(stable_brake)
    );

    assign brake = stable_brake;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_up   <= 1'b0;
            prev_down <= 1'b0;
        end else begin
            prev_up   <= stable_up;
            prev_down <= stable_down;
        end
    end

    assign up_event   = stable_up & ~prev_up;
    assign down_event = stable_down & ~prev_down;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            dropped <= 1'b0;
        end else begin
            state   <= next_state;
            dropped <= drop_next;
        end
    end

    // Requests never queue: anything arriving while one is pending is discarded
    always_comb begin
        next_state = state;
        drop_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (up_event && down_event) begin
                    drop_next = 1'b1;
                end else if (up_event) begin
                    if (stable_brake) drop_next = 1'b1;
                    else              next_state = PEND_UP;
                end else if (down_event) begin
                    next_state = PEND_DOWN;
                end
            end
            PEND_UP, PEND_DOWN: begin
                if (up_event || down_event) drop_next = 1'b1;
                if (tick) begin
                    next_state = IDLE;
                end else if (state == PEND_UP && stable_brake) begin
                    next_state = IDLE;
                    drop_next  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        shift_up   = (state == PEND_UP);
        shift_down = (state == PEND_DOWN);
    end

endmodule

// File: tb/tb_shift_request_conditioner.sv
// Directed bench for shift_request_conditioner with a window-based reference model.
module tb_shift_request_conditioner;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick;
    logic up_btn;
    logic down_btn;
    logic brake_btn;
    logic shift_up;
    logic shift_down;
    logic brake;
    logic dropped;

    int checks = 0;
    int errors = 0;
    int drop_cnt;

    shift_request_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .up_btn(up_btn), .down_btn(down_btn), .brake_btn(brake_btn),
        .shift_up(shift_up), .shift_down(shift_down),
        .brake(brake), .dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a level is accepted once the last DB synchronized samples
    // (each two edges old) all disagree with it, counting only samples since the last change.
    logic [2:0] hist[$];
    logic [2:0] m_stable;
    logic [2:0] m_prev;
    int         m_edges;
    int         m_last_flip[3];
    int         m_pend;
    logic       m_drop;
    logic       m_up_ev;
    logic       m_dn_ev;
    logic       m_all_diff;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_stable = '0;
            m_prev   = '0;
            m_pend   = 0;
            m_drop   = 1'b0;
            m_edges  = 0;
            for (int ch = 0; ch < 3; ch++) m_last_flip[ch] = 0;
            hist.delete();
            hist.push_back(3'b000);
            hist.push_back(3'b000);
        end else begin
            m_up_ev = m_stable[0] && !m_prev[0];
            m_dn_ev = m_stable[1] && !m_prev[1];
            m_drop  = 1'b0;
            if (m_pend == 0) begin
                if (m_up_ev && m_dn_ev)  m_drop = 1'b1;
                else if (m_up_ev)        begin if (m_stable[2]) m_drop = 1'b1; else m_pend = 1; end
                else if (m_dn_ev)        m_pend = 2;
            end else begin
                if (m_up_ev || m_dn_ev) m_drop = 1'b1;
                if (tick)                              m_pend = 0;
                else if (m_pend == 1 && m_stable[2])   begin m_pend = 0; m_drop = 1'b1; end
            end
            m_prev = m_stable;
            m_edges++;
            hist.push_back({brake_btn, down_btn, up_btn});
            for (int ch = 0; ch < 3; ch++) begin
                if (m_edges - DB >= m_last_flip[ch]) begin
                    m_all_diff = 1'b1;
                    for (int j = m_edges - DB + 1; j <= m_edges; j++)
                        if (hist[j-1][ch] == m_stable[ch]) m_all_diff = 1'b0;
                    if (m_all_diff) begin
                        m_stable[ch]    = ~m_stable[ch];
                        m_last_flip[ch] = m_edges;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset)
            check_output("cycle_outputs", {shift_up, shift_down, brake, dropped},
                         {m_pend == 1, m_pend == 2, m_stable[2], m_drop});
    end

    initial begin
        tick = 0; up_btn = 0; down_btn = 0; brake_btn = 0;
        step(3);
        check_output("reset_outputs", {shift_up, shift_down, brake, dropped}, 4'b0000);
        reset = 1'b1;
        step(2);

        // clean up press, consumed by a later tick
        up_btn = 1; step(6);
        check_output("t1_not_yet", {3'b0, shift_up}, 4'd0);
        step(1);
        check_output("t1_accepted", {3'b0, shift_up}, 4'd1);
        step(13); up_btn = 0; step(9);
        tick = 1;
        check_output("t1_tick_cycle", {2'b0, shift_up, shift_down}, 4'b0010);
        step(1); tick = 0;
        check_output("t1_after_tick", {2'b0, shift_up, shift_down}, 4'b0000);
        step(8);

        // bouncing button never reaches a stable level
        for (int i = 0; i < 6; i++) begin up_btn = ~up_btn; step(2); end
        step(10);
        check_output("t2_bounce", {3'b0, shift_up}, 4'd0);

        // simultaneous up and down
        up_btn = 1; down_btn = 1; drop_cnt = 0;
        for (int i = 0; i < 12; i++) begin step(1); drop_cnt += int'(dropped); end
        check_output("t3_drop_pulses", 4'(drop_cnt), 4'd1);
        tick = 1; step(1); tick = 0;
        check_output("t3_no_request", {2'b0, shift_up, shift_down}, 4'b0000);
        up_btn = 0; down_btn = 0; step(8);

        // upshift blocked by brake, downshift allowed
        brake_btn = 1; step(5);
        check_output("t4_brake_pre", {3'b0, brake}, 4'd0);
        step(1);
        check_output("t4_brake_on", {3'b0, brake}, 4'd1);
        up_btn = 1; drop_cnt = 0;
        for (int i = 0; i < 10; i++) begin step(1); drop_cnt += int'(dropped); end
        check_output("t4_up_dropped", 4'(drop_cnt), 4'd1);
        check_output("t4_no_up", {3'b0, shift_up}, 4'd0);
        up_btn = 0; step(8);
        down_btn = 1; step(7);
        check_output("t4_down_pending", {2'b0, shift_up, shift_down}, 4'b0001);
        step(3); tick = 1;
        check_output("t4_down_tick", {3'b0, shift_down}, 4'd1);
        step(1); tick = 0;
        check_output("t4_down_cleared", {3'b0, shift_down}, 4'd0);
        down_btn = 0; brake_btn = 0; step(10);

        // brake cancels a pending upshift
        up_btn = 1; step(8);
        check_output("t5_up_pending", {3'b0, shift_up}, 4'd1);
        brake_btn = 1; step(6);
        check_output("t5_brake_rise", {2'b0, brake, shift_up}, 4'b0011);
        step(1);
        check_output("t5_cancelled", {2'b0, shift_up, dropped}, 4'b0001);
        step(1);
        check_output("t5_drop_single", {3'b0, dropped}, 4'd0);
        step(3); tick = 1; step(1); tick = 0;
        check_output("t5_tick_noop", {2'b0, shift_up, shift_down}, 4'b0000);
        up_btn = 0; brake_btn = 0; step(10);

        // asynchronous reset mid-request
        down_btn = 1; step(8);
        check_output("t6_down_pending", {3'b0, shift_down}, 4'd1);
        #2 reset = 0;
        #1 check_output("t6_async_clear", {shift_up, shift_down, brake, dropped}, 4'b0000);
        @(negedge clk); step(2);
        reset = 1;
        step(6);
        check_output("t6_reaccept_pre", {3'b0, shift_down}, 4'd0);
        step(1);
        check_output("t6_reaccept", {3'b0, shift_down}, 4'd1);
        down_btn = 0; step(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
